mux_rr_arbiter: RTL and testbench

- Two-source round-robin arbiter stage feeding the team's 2:1 Mux block.
- Accepts words from two valid/ready producers (A, B) and picks one per transfer, round-robin when both request.
- Drives the Mux select line with the source of the held word.
- Holds the chosen word in a one-entry output register with a valid/ready handshake toward the consumer.

---
 rtl/mux_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Two-source round-robin arbiter with a one-entry output slot driving the 2:1 Mux select.
// Define MUX_RR_ARBITER_COUNT_EN to add per-source accepted-beat counters.
module mux_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] a_count,
  output logic [CNT_W-1:0] b_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d;
  logic             last_q, last_d;
  logic             gnt_a, gnt_b;
  logic             can_accept;
  logic             acc_a, acc_b;

  // On contention the source that did not win last time is granted.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    case ({a_valid, b_valid})
      2'b10:   gnt_a = 1'b1;
      2'b01:   gnt_b = 1'b1;
      2'b11: begin
        gnt_a = last_q;
        gnt_b = ~last_q;
      end
      default: ;
    endcase
  end

  assign can_accept = (state_q == EMPTY) | out_ready;
  assign a_ready    = can_accept & gnt_a;
  assign b_ready    = can_accept & gnt_b;
  assign acc_a      = a_valid & a_ready;
  assign acc_b      = b_valid & b_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (acc_a | acc_b) begin
      state_d = FULL;
      data_d  = acc_a ? a_data : b_data;
      sel_d   = acc_b;
      last_d  = acc_b;
    end else if (state_q == FULL && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign sel       = sel_q;

`ifdef MUX_RR_ARBITER_COUNT_EN
  logic [CNT_W-1:0] a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;

  always_comb begin
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (acc_a) a_cnt_d = a_cnt_q + 1'b1;
    if (acc_b) b_cnt_d = b_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign a_count = a_cnt_q;
  assign b_count = b_cnt_q;
`else
  assign a_count = '0;
  assign b_count = '0;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Bench for mux_rr_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of the slot and rotating priority.
module tb_mux_rr_arbiter;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid, b_valid, out_ready;
  logic [W-1:0]  a_data, b_data;
  logic          a_ready, b_ready, sel, out_valid;
  logic [W-1:0]  out_data;
  logic [CW-1:0] a_count, b_count;

  int total = 0;
  int bad   = 0;

  mux_rr_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready),
    .a_count(a_count), .b_count(b_count)
  );

  always #5 clk = ~clk;

  // model: slot contents, who won last, and plain integer beat tallies
  bit         m_valid;
  logic [W-1:0] m_data;
  bit         m_sel;
  bit         m_last;
  int         m_acnt, m_bcnt;

  wire [W+3:0]    dut_vec = {a_ready, b_ready, out_valid, sel, out_data};
  wire [2*CW-1:0] dut_cnt = {a_count, b_count};

  // 0 none, 1 A, 2 B
  function automatic int grant();
    if (a_valid && b_valid) return m_last ? 1 : 2;
    if (a_valid) return 1;
    if (b_valid) return 2;
    return 0;
  endfunction

  function automatic logic [W+3:0] exp_vec();
    int g;
    bit ca;
    g  = grant();
    ca = !m_valid || out_ready;
    return {ca && g == 1, ca && g == 2, m_valid, m_sel, m_data};
  endfunction

  function automatic logic [2*CW-1:0] exp_cnt();
`ifdef MUX_RR_ARBITER_COUNT_EN
    int ma, mb;
    logic [CW-1:0] ea, eb;
    ma = m_acnt % (1 << CW);
    mb = m_bcnt % (1 << CW);
    ea = ma[CW-1:0];
    eb = mb[CW-1:0];
    return {ea, eb};
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    m_valid = 0; m_data = '0; m_sel = 0; m_last = 1;
    m_acnt = 0; m_bcnt = 0;
  endtask

  task automatic model_step();
    int g;
    bit ca;
    g  = grant();
    ca = !m_valid || out_ready;
    if (ca && g == 1) begin
      m_valid = 1; m_data = a_data; m_sel = 0; m_last = 0; m_acnt++;
    end else if (ca && g == 2) begin
      m_valid = 1; m_data = b_data; m_sel = 1; m_last = 1; m_bcnt++;
    end else if (m_valid && out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic drive(input bit av, input logic [W-1:0] ad,
                       input bit bv, input logic [W-1:0] bd,
                       input bit ordy);
    @(negedge clk);
    a_valid = av; a_data = ad;
    b_valid = bv; b_data = bd;
    out_ready = ordy;
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1; a_valid = 0; b_valid = 0; out_ready = 0;
    a_data = '0; b_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    logic [W+3:0] ev;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, 0, 1);
      ev = exp_vec();
      total++;
      if (dut_vec !== ev || dut_cnt !== exp_cnt()) begin
        bad++;
        $display("FAIL reset_idle cyc%0d: got %h/%h want %h/%h",
                 i, dut_vec, dut_cnt, ev, exp_cnt());
      end
      model_step();
    end
  endtask

  task automatic test_single_a();
    logic [W-1:0] d [3] = '{8'h11, 8'h22, 8'h33};
    logic [W+3:0] ev;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      if (i < 3) drive(1, d[i], 0, 0, 1);
      else       drive(0, 0, 0, 0, 1);
      ev = exp_vec();
      total++;
      if (dut_vec !== ev) begin
        bad++;
        $display("FAIL single_a cyc%0d: got %h want %h", i, dut_vec, ev);
      end
      if (i > 0) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== d[i-1] || sel !== 1'b0) begin
          bad++;
          $display("FAIL single_a_word cyc%0d: got v%b %h s%b want v1 %h s0",
                   i, out_valid, out_data, sel, d[i-1]);
        end
      end
      model_step();
    end
    total++;
`ifdef MUX_RR_ARBITER_COUNT_EN
    if (a_count !== 4'd3 || b_count !== 4'd0) begin
`else
    if (a_count !== 4'd0 || b_count !== 4'd0) begin
`endif
      bad++;
      $display("FAIL single_a_count: got a%0d b%0d", a_count, b_count);
    end
  endtask

  task automatic test_contention();
    logic [W+3:0] ev;
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1, 8'hAA, 1, 8'hBB, 1);
      ev = exp_vec();
      total++;
      if (dut_vec !== ev) begin
        bad++;
        $display("FAIL contention cyc%0d: got %h want %h", i, dut_vec, ev);
      end
      if (i > 0) begin
        total++;
        if (out_data !== ((i % 2) ? 8'hAA : 8'hBB) || sel !== !(i % 2)) begin
          bad++;
          $display("FAIL contention_alt cyc%0d: got %h s%b", i, out_data, sel);
        end
      end
      model_step();
    end
  endtask

  task automatic test_backpressure();
    logic [W+3:0] ev;
    apply_reset();
    drive(1, 8'h5C, 0, 0, 0);
    model_step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 8'hAA, 1, 8'hBB, 0);
      ev = exp_vec();
      total++;
      if (dut_vec !== ev ||
          {a_ready, b_ready, out_valid, sel, out_data} !== {4'b0010, 8'h5C}) begin
        bad++;
        $display("FAIL stall cyc%0d: got %h want %h", i, dut_vec, ev);
      end
      model_step();
    end
    drive(1, 8'hAA, 1, 8'hBB, 1);
    ev = exp_vec();
    total++;
    if (dut_vec !== ev || b_ready !== 1'b1) begin
      bad++;
      $display("FAIL pop_refill: got %h want %h", dut_vec, ev);
    end
    model_step();
    drive(0, 0, 0, 0, 0);
    ev = exp_vec();
    total++;
    if (dut_vec !== ev || out_data !== 8'hBB || sel !== 1'b1) begin
      bad++;
      $display("FAIL refill_word: got %h want %h", dut_vec, ev);
    end
  endtask

  task automatic test_async_reset();
    logic [W+3:0] ev;
    apply_reset();
    drive(1, 8'h7E, 0, 0, 0);
    model_step();
    drive(0, 0, 0, 0, 0);
    #2;
    rst = 1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || sel !== 1'b0) begin
      bad++;
      $display("FAIL async_rst: got v%b %h s%b want v0 00 s0",
               out_valid, out_data, sel);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
    drive(1, 8'hAA, 1, 8'hBB, 1);
    ev = exp_vec();
    total++;
    if (dut_vec !== ev || a_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_rst_pref: got %h want %h", dut_vec, ev);
    end
    model_step();
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      drive(0, 0, 1, i[W-1:0], 1);
      model_step();
    end
    drive(0, 0, 0, 0, 1);
    total++;
`ifdef MUX_RR_ARBITER_COUNT_EN
    if (a_count !== 4'd0 || b_count !== 4'd1) begin
`else
    if (a_count !== 4'd0 || b_count !== 4'd0) begin
`endif
      bad++;
      $display("FAIL count_wrap: got a%0d b%0d", a_count, b_count);
    end
    total++;
    if (dut_cnt !== exp_cnt()) begin
      bad++;
      $display("FAIL count_model: got %h want %h", dut_cnt, exp_cnt());
    end
  endtask

  task automatic test_random();
    logic [W+3:0] ev;
    bit av, bv, ordy;
    logic [W-1:0] ad, bd;
    av = 0; bv = 0; ad = '0; bd = '0;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (!av && ($urandom % 3) != 0) begin av = 1; ad = W'($urandom); end
      if (!bv && ($urandom % 3) != 0) begin bv = 1; bd = W'($urandom); end
      ordy = ($urandom % 4) != 0;
      drive(av, ad, bv, bd, ordy);
      ev = exp_vec();
      total++;
      if (dut_vec !== ev || dut_cnt !== exp_cnt()) begin
        bad++;
        $display("FAIL random cyc%0d: got %h/%h want %h/%h",
                 i, dut_vec, dut_cnt, ev, exp_cnt());
      end
      model_step();
      if (ev[W+3]) av = 0;
      if (ev[W+2]) bv = 0;
    end
  endtask

  initial begin
    rst = 1; a_valid = 0; b_valid = 0; out_ready = 0;
    a_data = '0; b_data = '0;
    model_reset();
    test_reset();
    test_single_a();
    test_contention();
    test_backpressure();
    test_async_reset();
    test_counter_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
